// File: rtl/regfl_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// byte_merge is used by both the storage write path and the read-port bypass.
package regfl_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int BYTE       = 8;
    localparam int MAX_DATA_W = 512;
    localparam int MAX_LANES  = MAX_DATA_W / BYTE;

    // Operates at the widest supported word; callers zero-extend and truncate.
    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_data,
        input logic [MAX_DATA_W-1:0] new_data,
        input logic [MAX_LANES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        for (int k = 0; k < MAX_LANES; k++) begin
            res[k*BYTE +: BYTE] = be[k] ? new_data[k*BYTE +: BYTE] : old_data[k*BYTE +: BYTE];
        end
        return res;
    endfunction

endpackage

// File: rtl/regfl_rd_port.sv
// Registered read port: selects clear-bypass zero, write bypass, or stored word.
module regfl_rd_port
    import regfl_pkg::*;
#(
    parameter int address_width = 3,
    parameter int data_width    = 64
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     re,
    input  logic [address_width-1:0] raddr,
    input  logic [data_width-1:0]    mem_word,
    input  logic                     byp_en,
    input  logic [address_width-1:0] waddr,
    input  logic [data_width-1:0]    byp_data,
    input  logic                     clr_en,
    input  logic [address_width-1:0] clr_addr,
    output logic [data_width-1:0]    rdata
);

    logic                  hit_clr;
    logic                  hit_byp;
    logic [data_width-1:0] rdata_next;

    // A register being zeroed this edge reads as zero; a register being written reads merged.
    always_comb begin
        hit_clr    = clr_en && (raddr == clr_addr);
        hit_byp    = byp_en && (raddr == waddr);
        rdata_next = mem_word;
        if (hit_clr) begin
            rdata_next = '0;
        end else if (hit_byp) begin
            rdata_next = byp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rdata_next;
        end
    end

endmodule

// File: rtl/regfl_2r1w.sv
// Register file, one byte-masked write port, two registered read ports, swept bulk clear.
// Build option: REGFL_ZERO_REG_EN hardwires register 0 to zero.
module regfl_2r1w
    import regfl_pkg::*;
#(
    parameter  int address_width  = 3,
    parameter  int register_count = 2**address_width,
    parameter  int data_width     = 64,
    localparam int lane_count     = data_width / BYTE
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     we,
    input  logic [address_width-1:0] waddr,
    input  logic [data_width-1:0]    wdata,
    input  logic [lane_count-1:0]    wbe,
    input  logic                     re_a,
    input  logic [address_width-1:0] raddr_a,
    output logic [data_width-1:0]    rdata_a,
    input  logic                     re_b,
    input  logic [address_width-1:0] raddr_b,
    output logic [data_width-1:0]    rdata_b,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam logic [address_width-1:0] LAST_PTR = address_width'(register_count - 1);

    state_t                   state;
    logic [address_width-1:0] ptr;
    logic [data_width-1:0]    mem [register_count];
    logic                     write_ok;
    logic                     clearing;
    logic [data_width-1:0]    merged;
    logic [data_width-1:0]    word_a;
    logic [data_width-1:0]    word_b;

    function automatic logic addr_valid(input logic [address_width-1:0] addr);
`ifdef REGFL_ZERO_REG_EN
        return (32'(addr) < register_count) && (addr != '0);
`else
        return 32'(addr) < register_count;
`endif
    endfunction

    function automatic logic [data_width-1:0] read_word(input logic [address_width-1:0] addr);
        return addr_valid(addr) ? mem[addr] : '0;
    endfunction

    // clear_req in IDLE takes priority over a same-cycle write.
    assign clearing = (state == CLEAR);
    assign busy     = clearing;
    assign write_ok = (state == IDLE) && we && !clear_req && addr_valid(waddr);
    assign merged   = data_width'(byte_merge(MAX_DATA_W'(read_word(waddr)), MAX_DATA_W'(wdata),
                                             MAX_LANES'(wbe)));
    assign word_a   = read_word(raddr_a);
    assign word_b   = read_word(raddr_b);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < register_count; i++) begin
                mem[i] <= '0;
            end
        end else if (clearing) begin
            mem[ptr] <= '0;
        end else if (write_ok) begin
            mem[waddr] <= merged;
        end
    end

    regfl_rd_port #(
        .address_width(address_width),
        .data_width   (data_width)
    ) u_rd_a (
        .clk     (clk),
        .rst_b   (rst_b),
        .re      (re_a),
        .raddr   (raddr_a),
        .mem_word(word_a),
        .byp_en  (write_ok),
        .waddr   (waddr),
        .byp_data(merged),
        .clr_en  (clearing),
        .clr_addr(ptr),
        .rdata   (rdata_a)
    );

    regfl_rd_port #(
        .address_width(address_width),
        .data_width   (data_width)
    ) u_rd_b (
        .clk     (clk),
        .rst_b   (rst_b),
        .re      (re_b),
        .raddr   (raddr_b),
        .mem_word(word_b),
        .byp_en  (write_ok),
        .waddr   (waddr),
        .byp_data(merged),
        .clr_en  (clearing),
        .clr_addr(ptr),
        .rdata   (rdata_b)
    );

endmodule

// File: tb/tb_regfl_2r1w.sv
// Self-checking bench for regfl_2r1w: vector table, directed clear/reset sequences, random traffic.
module tb_regfl_2r1w;

    logic        clk;
    logic        rst_b;
    logic        we;
    logic [2:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        re_a;
    logic [2:0]  raddr_a;
    logic [63:0] rdata_a;
    logic        re_b;
    logic [2:0]  raddr_b;
    logic [63:0] rdata_b;
    logic        clear_req;
    logic        busy;

    regfl_2r1w dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wbe      (wbe),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .clear_req(clear_req),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [63:0] wdata;
        logic [7:0]  wbe;
        logic        re_a;
        logic [2:0]  raddr_a;
        logic        re_b;
        logic [2:0]  raddr_b;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    int          busy_cycles = 0;
    logic [128:0] exp_q[$];
    string       tag_q[$];

    // reference model: memory contents after each edge, reads see post-edge contents
    logic [63:0] m_mem[8];
    logic        m_busy;
    int          m_ptr;
    logic [63:0] m_a;
    logic [63:0] m_b;

`ifdef REGFL_ZERO_REG_EN
    localparam logic [63:0] REG0_EXP = 64'h0;
`else
    localparam logic [63:0] REG0_EXP = 64'hFFFF;
`endif

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_busy = 1'b0;
        m_ptr  = 0;
        m_a    = '0;
        m_b    = '0;
    endtask

    task automatic model_step(input logic i_we, input logic [2:0] i_waddr, input logic [63:0] i_wdata,
                              input logic [7:0] i_wbe, input logic i_re_a, input logic [2:0] i_raddr_a,
                              input logic i_re_b, input logic [2:0] i_raddr_b, input logic i_clr);
        logic wr;
        wr = !m_busy && i_we && !i_clr;
`ifdef REGFL_ZERO_REG_EN
        if (i_waddr == 3'd0) wr = 1'b0;
`endif
        if (wr) begin
            for (int k = 0; k < 8; k++) begin
                if (i_wbe[k]) m_mem[i_waddr][k*8 +: 8] = i_wdata[k*8 +: 8];
            end
        end
        if (m_busy) begin
            m_mem[m_ptr] = '0;
            m_ptr++;
            if (m_ptr == 8) begin
                m_busy = 1'b0;
                m_ptr  = 0;
            end
        end else if (i_clr) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end
        if (i_re_a) m_a = m_mem[i_raddr_a];
        if (i_re_b) m_b = m_mem[i_raddr_b];
    endtask

    // One clock: drive inputs, push expectation, take the edge, pop and compare.
    task automatic drive(input logic i_we, input logic [2:0] i_waddr, input logic [63:0] i_wdata,
                         input logic [7:0] i_wbe, input logic i_re_a, input logic [2:0] i_raddr_a,
                         input logic i_re_b, input logic [2:0] i_raddr_b, input logic i_clr,
                         input logic use_tab, input logic [63:0] tab_a, input logic [63:0] tab_b,
                         input string tag);
        logic [128:0] e;
        string        t;
        we        = i_we;
        waddr     = i_waddr;
        wdata     = i_wdata;
        wbe       = i_wbe;
        re_a      = i_re_a;
        raddr_a   = i_raddr_a;
        re_b      = i_re_b;
        raddr_b   = i_raddr_b;
        clear_req = i_clr;
        model_step(i_we, i_waddr, i_wdata, i_wbe, i_re_a, i_raddr_a, i_re_b, i_raddr_b, i_clr);
        exp_q.push_back({m_busy, use_tab ? tab_a : m_a, use_tab ? tab_b : m_b});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_busy"}, {63'd0, busy}, {63'd0, e[128]});
        check({t, "_rdata_a"}, rdata_a, e[127:64]);
        check({t, "_rdata_b"}, rdata_b, e[63:0]);
        if (busy) busy_cycles++;
    endtask

    task automatic nop(input string tag);
        drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, tag);
    endtask

    task automatic fill_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), {$urandom, $urandom}, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                  1'b0, 64'd0, 64'd0, tag);
        end
    endtask

    initial begin
        logic [63:0] d1;

        vecs[0] = '{1'b1, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 64'h0, 64'h0};
        vecs[1] = '{1'b1, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b0, 3'd0, 1'b0, 3'd0, 64'h0, 64'h0};
        vecs[2] = '{1'b0, 3'd0, 64'h0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd3,
                    64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA};
        vecs[3] = '{1'b1, 3'd5, 64'h000000000000DEAD, 8'h03, 1'b1, 3'd5, 1'b1, 3'd5,
                    64'h000000000000DEAD, 64'h000000000000DEAD};
        vecs[4] = '{1'b0, 3'd0, 64'h0, 8'h00, 1'b0, 3'd1, 1'b0, 3'd2,
                    64'h000000000000DEAD, 64'h000000000000DEAD};
        vecs[5] = '{1'b0, 3'd0, 64'h0, 8'h00, 1'b1, 3'd3, 1'b1, 3'd7, 64'h11223344AAAAAAAA, 64'h0};
        vecs[6] = '{1'b1, 3'd0, 64'h000000000000FFFF, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0, REG0_EXP, REG0_EXP};
        vecs[7] = '{1'b1, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 3'd3, 1'b1, 3'd0,
                    64'h11223344AAAAAAAA, REG0_EXP};

        // reset
        rst_b = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0; clear_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rdata_a", rdata_a, 64'd0);
        check("reset_rdata_b", rdata_b, 64'd0);
        rst_b = 1'b1;

        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b1, 3'(a), 1'b1, 3'(a), 1'b0, 1'b1, 64'd0, 64'd0, "post_reset_read");
        end

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wbe, vecs[i].re_a, vecs[i].raddr_a,
                  vecs[i].re_b, vecs[i].raddr_b, 1'b0, 1'b1, vecs[i].exp_a, vecs[i].exp_b,
                  $sformatf("vec%0d", i));
        end

        // bulk clear with a colliding write, we and clear_req pulses during the sweep
        fill_all("fill1");
        busy_cycles = 0;
        drive(1'b1, 3'd2, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1,
              1'b0, 64'd0, 64'd0, "clear_start");
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom}, 8'hFF,
                  1'b1, 3'(i), 1'b1, 3'($urandom_range(0, 7)), (i == 3), 1'b0, 64'd0, 64'd0, "sweep");
        end
        check("busy_cycle_count", 64'(busy_cycles), 64'd8);
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b1, 3'(a), 1'b1, 3'(7 - a), 1'b0, 1'b1, 64'd0, 64'd0,
                  "post_clear_read");
        end

        // reset in the middle of a sweep, then a fresh sweep must restart at register 0
        fill_all("fill2");
        drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 64'd0, 64'd0, "clear2_start");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b1, 3'd7, 1'b1, 3'd6, 1'b0, 1'b0, 64'd0, 64'd0, "sweep2");
        end
        #3;
        rst_b = 1'b0;
        #1;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_rdata_a", rdata_a, 64'd0);
        check("midreset_rdata_b", rdata_b, 64'd0);
        model_reset();
        #3;
        rst_b = 1'b1;
        d1 = 64'h0123456789ABCDEF;
        drive(1'b1, 3'd0, 64'h5555AAAA5555AAAA, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 64'd0, 64'd0, "w0");
        drive(1'b1, 3'd1, d1, 8'hFF, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0, 1'b1, 64'd0, 64'd0, "w1");
        drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 64'd0, 64'd0, "clear3_start");
        drive(1'b0, 3'd0, 64'd0, 8'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0, 1'b1, 64'd0, d1, "restart_ptr0");
        for (int i = 0; i < 7; i++) nop("sweep3");
        nop("idle_after_sweep3");

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 24) == 0),
                  1'b0, 64'd0, 64'd0, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
